pipe_pattern_rng: RTL and testbench



---
 rtl/pipe_pattern_rng_if.sv | 12 +
 rtl/pipe_pattern_rng.sv | 51 +++++
 tb/tb_pipe_pattern_rng.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/pipe_pattern_rng_if.sv
// Purpose: connection bundle between the pipe scheduler and the pipe pattern RNG.
// Ports:   sel/incr (scheduler -> rng), rng/newPipe (rng -> scheduler).
// Modports: master = scheduler side, slave = pipe_pattern_rng side.
interface pipe_pattern_rng_if;
  logic        sel;      // game-tick enable
  logic        incr;     // advance request, one step per qualifying clock
  logic [7:0]  rng;      // current LFSR state (registered)
  logic [15:0] newPipe;  // pipe column, bit i = LED row i, 1 = lit

  modport master (output sel, output incr, input rng, input newPipe);
  modport slave  (input sel, input incr, output rng, output newPipe);
endinterface

// File: rtl/pipe_pattern_rng.sv
// Purpose: 8-bit maximal-length LFSR plus a map from its value to a 16-row pipe column with a 4-row gap.
// Latency: rng changes one clock after a qualifying sel&incr; newPipe follows rng combinationally.
// Backpressure: none; the scheduler samples rng/newPipe whenever it likes, and sel gates every step.
// Ports: clk, reset (sync, active-high), bus (slave modport: sel, incr in; rng, newPipe out).
module pipe_pattern_rng #(
  parameter logic [7:0] SEED = 8'h01
) (
  input  logic               clk,
  input  logic               reset,
  pipe_pattern_rng_if.slave  bus
);

  logic [7:0]  rng_q;
  logic [7:0]  rng_d;
  logic        fb;
  logic [3:0]  gap_top;
  logic [15:0] new_pipe;

  // Fibonacci feedback for x^8+x^6+x^5+x^4+1.
  always_comb begin
    fb    = rng_q[7] ^ rng_q[5] ^ rng_q[4] ^ rng_q[3];
    rng_d = rng_q;
    if (bus.sel && bus.incr) begin
      rng_d = {rng_q[6:0], fb};
    end else if (rng_q == 8'h00) begin
      // All-zero is a dead state for this LFSR; reload so it can never stick.
      rng_d = SEED;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rng_q <= SEED;
    end else begin
      rng_q <= rng_d;
    end
  end

  // Gap top row: low nibble folded so a 4-row gap always fits in rows 0..15.
  always_comb begin
    gap_top = rng_q[3:0];
    if (rng_q[3:0] > 4'd12) begin
      gap_top = rng_q[3:0] - 4'd13;
    end
    new_pipe = ~(16'h000F << gap_top);
  end

  assign bus.rng     = rng_q;
  assign bus.newPipe = new_pipe;

endmodule

// File: tb/tb_pipe_pattern_rng.sv
module tb_pipe_pattern_rng;

  localparam logic [7:0] SEED = 8'h01;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;
  logic [7:0] m_rng;          // reference model state
  bit   seen [256];

  pipe_pattern_rng_if bus ();

  pipe_pattern_rng #(.SEED(SEED)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Reference LFSR: feedback is the XOR of the state bits named by the
  // polynomial's tap exponents (8,6,5,4 -> bits 7,5,4,3), shifted in at the bottom.
  function automatic logic [7:0] model_step(input logic [7:0] r);
    int taps [4] = '{7, 5, 4, 3};
    logic f;
    f = 1'b0;
    foreach (taps[k]) f = f ^ r[taps[k]];
    return {r[6:0], f};
  endfunction

  // Reference pipe map: row by row, dark if inside the 4-row gap.
  function automatic logic [15:0] model_pipe(input logic [7:0] r);
    int g;
    logic [15:0] p;
    g = int'(r) % 16;
    if (g > 12) g = g - 13;
    for (int i = 0; i < 16; i++) p[i] = !((i >= g) && (i <= g + 3));
    return p;
  endfunction

  function automatic int longest_zero_run(input logic [15:0] p);
    int run, best;
    run = 0;
    best = 0;
    for (int i = 0; i < 16; i++) begin
      run = p[i] ? 0 : run + 1;
      if (run > best) best = run;
    end
    return best;
  endfunction

  // One clock: model follows the update rule using the inputs held across the edge.
  task automatic step();
    @(posedge clk);
    if (reset)                    m_rng = SEED;
    else if (bus.sel && bus.incr) m_rng = model_step(m_rng);
    else if (m_rng == 8'h00)      m_rng = SEED;
    #1;
  endtask

  task automatic check_state(input string tag);
    check_eq({tag, "_rng"},  {8'h00, bus.rng}, {8'h00, m_rng});
    check_eq({tag, "_pipe"}, bus.newPipe, model_pipe(m_rng));
  endtask

  logic [7:0] exp_seq [7] = '{8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47, 8'h8E};

  initial begin
    n_checks = 0;
    n_errors = 0;
    m_rng    = 8'hxx;
    reset    = 1'b1;
    bus.sel  = 1'b1;
    bus.incr = 1'b1;

    // Reset held 2 cycles with sel/incr active: reset must win.
    step();
    step();
    check_eq("reset_rng",  {8'h00, bus.rng}, 16'h0001);
    check_eq("reset_pipe", bus.newPipe, 16'hFFE1);

    // Stepping from the seed.
    reset = 1'b0;
    for (int k = 0; k < 7; k++) begin
      step();
      check_eq($sformatf("seq%0d_rng", k), {8'h00, bus.rng}, {8'h00, exp_seq[k]});
      check_eq($sformatf("seq%0d_pipe", k), bus.newPipe, model_pipe(exp_seq[k]));
    end

    // incr without sel is ignored.
    bus.sel = 1'b0;
    bus.incr = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check_eq("gate_nosel", {8'h00, bus.rng}, 16'h008E);
    end
    // sel without incr holds.
    bus.sel = 1'b1;
    bus.incr = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check_eq("gate_noincr", {8'h00, bus.rng}, 16'h008E);
    end
    bus.incr = 1'b1;
    step();
    check_eq("resume", {8'h00, bus.rng}, 16'h001C);
    check_state("resume");

    // Reset mid-sequence with stepping requested.
    reset = 1'b1;
    step();
    check_eq("midreset", {8'h00, bus.rng}, 16'h0001);
    reset = 1'b0;

    // Full period walk with exhaustive map properties.
    foreach (seen[v]) seen[v] = 1'b0;
    seen[1] = 1'b1;
    for (int k = 1; k <= 255; k++) begin
      step();
      check_state("walk");
      check_eq("walk_ones", 16'($countones(bus.newPipe)), 16'd12);
      check_eq("walk_gap",  16'(longest_zero_run(bus.newPipe)), 16'd4);
      if (k < 255) begin
        check_eq("walk_nozero", {15'd0, bus.rng == 8'h00}, 16'd0);
        check_eq("walk_norepeat", {15'd0, seen[bus.rng]}, 16'd0);
        seen[bus.rng] = 1'b1;
      end else begin
        check_eq("walk_period", {8'h00, bus.rng}, 16'h0001);
      end
      if (bus.rng == 8'h0C) check_eq("map_0c", bus.newPipe, 16'h0FFF);
      if (bus.rng == 8'h0D) check_eq("map_0d", bus.newPipe, 16'hFFF0);
      if (bus.rng == 8'h0F) check_eq("map_0f", bus.newPipe, 16'hFFC3);
    end

    // Lockup guard: plant the all-zero state, then idle one clock.
    bus.sel  = 1'b0;
    bus.incr = 1'b0;
    force dut.rng_q = 8'h00;
    #1;
    check_eq("zero_pipe", bus.newPipe, 16'hFFF0);
    release dut.rng_q;
    m_rng = 8'h00;
    step();
    check_eq("lockup_reload", {8'h00, bus.rng}, 16'h0001);

    // Randomized traffic against the model.
    for (int k = 0; k < 500; k++) begin
      reset    = ($urandom_range(0, 49) == 0);
      bus.sel  = 1'($urandom);
      bus.incr = 1'($urandom);
      step();
      check_state("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
